// File: rtl/port2_uart_tx.sv
// Debounces the CPU port-2 value, queues each new stable value and sends it as a UART frame.
// Define PORT2_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module port2_uart_tx #(
    parameter int unsigned CLK_DIV       = 868,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] port2_data,
    input  logic       enable,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    localparam logic [CntW-1:0] StableMax = CntW'(STABLE_CYCLES);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [OccW-1:0] OccFull   = OccW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef PORT2_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // Capture / debounce
    logic [6:0]      sample_q, cand_q, cand_d, last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            reach, commit;

    // FIFO
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [OccW-1:0] count_q;
    logic            empty, push, pop, drop, overflow_q;

    // Transmitter
    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d, div_end;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        reach  = 1'b0;
        if (sample_q != cand_q) begin
            cand_d = sample_q;
            cnt_d  = CntW'(1);
            reach  = (STABLE_CYCLES == 1);
        end else if (cnt_q != StableMax) begin
            cnt_d = cnt_q + CntW'(1);
            reach = (cnt_d == StableMax);
        end
        commit = reach && enable && (cand_d != last_q);
        last_d = commit ? cand_d : last_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            sample_q <= port2_data;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign empty     = (count_q == '0);
    assign fifo_full = (count_q == OccFull);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push      = commit && (!fifo_full || pop);
    assign drop      = commit && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_q] <= {1'b0, cand_d};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + OccW'(1);
                2'b01:   count_q <= count_q - OccW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;
        div_end = (div_q == DivLast);
        if (state_q != StIdle) begin
            div_d = div_end ? '0 : div_q + DivW'(1);
        end
        case (state_q)
            StIdle: begin
                if (enable && !empty) begin
                    pop     = 1'b1;
                    data_d  = mem[rd_q];
                    div_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (div_end) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (div_end) begin
                    if (bit_q == 3'd7) begin
`ifdef PORT2_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef PORT2_TX_PARITY_EN
            StParity: begin
                if (div_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (div_end) begin
                    if (enable && !empty) begin
                        pop     = 1'b1;
                        data_d  = mem[rd_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The line level follows the current state one cycle later, from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_q[bit_q];
`ifdef PORT2_TX_PARITY_EN
            StParity: tx_d = ^data_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_port2_uart_tx.sv
// Scoreboard bench for port2_uart_tx: stimulus queues expected bytes, a line monitor decodes frames.
module tb_port2_uart_tx;

    localparam int ClkDiv = 4;
`ifdef PORT2_TX_PARITY_EN
    localparam int FrameLen = 11 * ClkDiv;
`else
    localparam int FrameLen = 10 * ClkDiv;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [6:0] port2_data = 7'h00;
    logic       tx, busy, fifo_full, overflow;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    port2_uart_tx #(
        .CLK_DIV      (ClkDiv),
        .STABLE_CYCLES(4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .port2_data(port2_data),
        .enable    (enable),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame monitor: samples the middle of every bit on the falling clock edge.
    initial begin : monitor
        logic [7:0] rx;
        logic       start_ok, par_ok, stop_ok, aborted;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (reset && !tx) begin
                aborted = 1'b0;
                repeat (2) @(negedge clock);
                start_ok = !tx;
                aborted |= !reset;
                for (int i = 0; i < 8; i++) begin
                    repeat (ClkDiv) @(negedge clock);
                    rx[i] = tx;
                    aborted |= !reset;
                end
                par_ok = 1'b1;
`ifdef PORT2_TX_PARITY_EN
                repeat (ClkDiv) @(negedge clock);
                par_ok = (tx == ^rx);
                aborted |= !reset;
`endif
                repeat (ClkDiv) @(negedge clock);
                stop_ok = tx;
                aborted |= !reset;
                if (!aborted) begin
                    check("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("frame_data", int'({stop_ok, par_ok, start_ok, rx}),
                              int'({3'b111, e}));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b0;
        port2_data = 7'h00;
        enable     = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Counts cycles with any line or busy activity.
    task automatic watch(input int n, output int act);
        act = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (!tx || busy) act++;
        end
    endtask

    task automatic measure_frame(input int n, output int first_low, output int busy_cnt);
        first_low = -1;
        busy_cnt  = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clock);
            #1;
            if (!tx && first_low < 0) first_low = c;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int act, first_low, busy_cnt, ovf_cnt, full_seen;

        #2 reset = 1'b0;
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_full", int'(fifo_full), 0);
        check("reset_overflow", int'(overflow), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Unchanged zero value never commits.
        watch(100, act);
        check("idle_no_frame", act, 0);

        // Single value: latency and frame length.
        do_reset();
        exp_q.push_back(8'h3F);
        @(posedge clock);
        #1 port2_data = 7'h3F;
        measure_frame(70, first_low, busy_cnt);
        check("start_latency", first_low, 7);
        check("busy_len_3f", busy_cnt, FrameLen);

        // Short glitch does not commit.
        do_reset();
        @(posedge clock);
        #1 port2_data = 7'h06;
        repeat (2) @(posedge clock);
        #1 port2_data = 7'h00;
        watch(60, act);
        check("glitch_no_frame", act, 0);

        // Fill the FIFO and overflow once.
        do_reset();
        for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
        ovf_cnt   = 0;
        full_seen = 0;
        @(posedge clock);
        #1;
        for (int v = 1; v <= 6; v++) begin
            port2_data = 7'(v);
            repeat (5) begin
                @(posedge clock);
                #1;
                ovf_cnt += int'(overflow);
                if (fifo_full) full_seen = 1;
            end
        end
        repeat (260) begin
            @(posedge clock);
            #1;
            ovf_cnt += int'(overflow);
        end
        check("overflow_pulses", ovf_cnt, 1);
        check("fifo_full_seen", full_seen, 1);
        check("burst_drained", exp_q.size(), 0);
        check("burst_busy_end", int'(busy), 0);

        // Reset mid-frame discards everything.
        do_reset();
        @(posedge clock);
        #1 port2_data = 7'h55;
        repeat (5) @(posedge clock);
        #1 port2_data = 7'h11;
        repeat (5) @(posedge clock);
        #1 port2_data = 7'h22;
        repeat (10) @(posedge clock);
        #3;
        port2_data = 7'h00;
        reset      = 1'b0;
        #1;
        check("midframe_reset_tx", int'(tx), 1);
        check("midframe_reset_busy", int'(busy), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        watch(100, act);
        check("after_reset_no_frame", act, 0);

        // Value with three ones: odd data, parity bit 1 when enabled.
        do_reset();
        exp_q.push_back(8'h07);
        @(posedge clock);
        #1 port2_data = 7'h07;
        measure_frame(70, first_low, busy_cnt);
        check("busy_len_07", busy_cnt, FrameLen);
        watch(20, act);
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
